// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a byte FIFO with a ready/valid output stream.
// Define UART_RX_PARITY_EN for an even-parity bit and the o_parity_err flag.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_rx,
  input  logic                          i_clr,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          o_parity_err,
`endif
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            sync1_q;
  logic            sync2_q;
  logic            frame_err_q;
  logic            overflow_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   rp_q;
  logic [LW-1:0]   cnt_q;

  logic rxs;
  logic tick;
  logic push;
  logic pop;
  logic full;
  logic wr;

  assign rxs  = sync2_q;
  assign tick = (baud_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  assign o_parity_err = parity_err_q;
  assign push = (state_q == S_STOP) && tick && rxs && !par_bad_q;
`else
  assign push = (state_q == S_STOP) && tick && rxs;
`endif

  assign full = (cnt_q == DEPTH);
  assign pop  = o_valid && i_ready;
  assign wr   = push && (!full || pop);

  assign o_data      = mem_q[rp_q];
  assign o_valid     = (cnt_q != '0);
  assign o_level     = cnt_q;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

  // Two-flop synchronizer on the idle-high serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM: mid-bit sampling, byte assembly and sticky line errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (i_clr) begin
        frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      if (!tick) begin
        baud_q <= baud_q - 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            baud_q  <= HALF;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rxs) begin
              state_q <= S_IDLE;
            end else begin
              baud_q  <= FULL;
              bit_q   <= '0;
              state_q <= S_DATA;
`ifdef UART_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= {rxs, shift_q[7:1]};
            baud_q  <= FULL;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            baud_q  <= FULL;
            state_q <= S_STOP;
            if ((^shift_q) != rxs) begin
              par_bad_q    <= 1'b1;
              parity_err_q <= 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (rxs) begin
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte FIFO; a pop in the same cycle frees the slot for a push when full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= shift_q;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (i_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (8N1 build, CLKS_PER_BIT=16, depth 4).
// Random and directed frames checked against a queue-based byte model.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_clr = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_level;
  logic       o_frame_err;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int t_start = 0;
  int t0 = 0;

  logic [7:0] exp_q[$];
  bit exp_fe = 1'b0;
  bit exp_ovf = 1'b0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_rx(i_rx),
    .i_clr(i_clr),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_level(o_level),
    .o_frame_err(o_frame_err),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Consumer-side scoreboard: every accepted byte must match the model head
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && rise_cyc < 0) rise_cyc = cyc;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("pop_unexp", 32'd1, 32'd0);
        else chk("data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Model: a good frame enters the FIFO if a slot is free or one frees now
  task automatic model_push(input logic [7:0] b, input bit pop_now);
    if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    i_clr = 1'b1;
    idle(1);
    i_clr = 1'b0;
  endtask

  // Drives the first nbits of a 10-bit frame; a short frame ends idle-high
  task automatic send(input logic [7:0] b, input bit stop_v,
                      input int nbits, input bit pop_at_stop);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    t_start = cyc;
    for (int k = 0; k < nbits; k++) begin
      i_rx = fr[k];
      if (k == 9) begin
        if (stop_v) model_push(b, pop_at_stop);
        else exp_fe = 1'b1;
      end
      if (k == 9 && pop_at_stop) begin
        repeat (10) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (CPB - 11) @(posedge clk);
        #1;
      end else begin
        idle(CPB);
      end
    end
    if (nbits < 10) i_rx = 1'b1;
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    idle(3);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_level", {29'd0, o_level}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_fe", {31'd0, o_frame_err}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    i_ready = 1'b1;
    send(8'h55, 1'b1, 10, 1'b0);
    t0 = t_start;
    idle(2);
    send(8'hA3, 1'b1, 10, 1'b0);
    send(8'h00, 1'b1, 10, 1'b0);
    for (int n = 0; n < 4; n++) send(rnd8(), 1'b1, 10, 1'b0);
    idle(4);
    chk("latency", rise_cyc - t0, 32'd155);
    chk("drain1", exp_q.size(), 32'd0);
    chk("fe1", {31'd0, o_frame_err}, {31'd0, exp_fe});
    chk("ovf1", {31'd0, o_overflow}, {31'd0, exp_ovf});

    i_ready = 1'b0;
    i_rx = 1'b0;
    idle(4);
    i_rx = 1'b1;
    idle(30);
    chk("glitch_valid", {31'd0, o_valid}, 32'd0);
    chk("glitch_fe", {31'd0, o_frame_err}, 32'd0);

    i_ready = 1'b1;
    send(8'h7E, 1'b0, 10, 1'b0);
    idle(40);
    i_rx = 1'b1;
    idle(20);
    chk("fe_set", {31'd0, o_frame_err}, {31'd0, exp_fe});
    send(8'h31, 1'b1, 10, 1'b0);
    idle(4);
    chk("after_break", exp_q.size(), 32'd0);
    clr_pulse();
    exp_fe = 1'b0;
    chk("fe_clr", {31'd0, o_frame_err}, {31'd0, exp_fe});

    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1, 10, 1'b0);
    idle(2);
    chk("ovf_level", {29'd0, o_level}, exp_q.size());
    chk("ovf_set", {31'd0, o_overflow}, {31'd0, exp_ovf});
    i_ready = 1'b1;
    idle(8);
    i_ready = 1'b0;
    chk("ovf_drain", {29'd0, o_level}, 32'd0);
    chk("ovf_left", exp_q.size(), 32'd0);
    clr_pulse();
    exp_ovf = 1'b0;
    chk("ovf_clr", {31'd0, o_overflow}, {31'd0, exp_ovf});

    for (int n = 0; n < 4; n++) send(rnd8(), 1'b1, 10, 1'b0);
    send(rnd8(), 1'b1, 10, 1'b1);
    idle(2);
    chk("pp_level", {29'd0, o_level}, exp_q.size());
    chk("pp_ovf", {31'd0, o_overflow}, {31'd0, exp_ovf});
    i_ready = 1'b1;
    idle(8);
    i_ready = 1'b0;
    chk("pp_left", exp_q.size(), 32'd0);

    send(rnd8(), 1'b1, 10, 1'b0);
    send(rnd8(), 1'b1, 10, 1'b0);
    chk("pre_rst_level", {29'd0, o_level}, exp_q.size());
    send(8'h99, 1'b1, 5, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_level", {29'd0, o_level}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    i_ready = 1'b1;
    send(8'h42, 1'b1, 10, 1'b0);
    idle(4);
    chk("post_rst", exp_q.size(), 32'd0);
    chk("post_rst_fe", {31'd0, o_frame_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
